// File: rtl/bist_race_monitor.sv
// bist_race_monitor
// Launches the BICS-BIST and STRAIT engines from one shared start level,
// measures how many cycles each takes to raise its done level, captures the
// pass/fail flag that accompanies that first done, and guards the race with
// a watchdog. The finished record is held behind a valid/ack handshake.

module bist_race_monitor #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 5000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    output logic                 busy,
    output logic                 bist_start,
    input  logic                 bics_done,
    input  logic                 bics_error,
    input  logic                 strait_done,
    input  logic                 strait_error,
    output logic [CNT_WIDTH-1:0] bics_cycles,
    output logic [CNT_WIDTH-1:0] strait_cycles,
    output logic                 bics_fail,
    output logic                 strait_fail,
    output logic                 timeout,
    output logic [1:0]           faster,
    output logic                 result_valid,
    input  logic                 result_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Saturation value for the counter, doubling as the "never finished"
    // latency marker for an engine the watchdog gave up on.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    // The watchdog fires on the last legal RUN cycle, so a capture on that
    // very cycle still wins over the timeout.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t state;
    state_t state_next;

    logic [CNT_WIDTH-1:0] cnt;
    logic                 bics_got;
    logic                 strait_got;

    logic                 start_run;
    logic                 bics_cap;
    logic                 strait_cap;
    logic                 bics_have;
    logic                 strait_have;
    logic                 both_have;
    logic                 run_exit;
    logic                 report_done;
    logic [CNT_WIDTH-1:0] bics_lat;
    logic [CNT_WIDTH-1:0] strait_lat;
    logic [1:0]           faster_next;

    // State register; reset always lands in IDLE, discarding any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision: IDLE waits for a request, RUN waits for both
    // captures or the watchdog, REPORT waits for the consumer's ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_run)   state_next = RUN;
            RUN:     if (run_exit)    state_next = REPORT;
            REPORT:  if (report_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes: which engine captures this cycle, whether the race is
    // over, and which engine wins if it is.
    always_comb begin
        start_run   = (state == IDLE) && run_req;
        bics_cap    = (state == RUN) && bics_done && !bics_got;
        strait_cap  = (state == RUN) && strait_done && !strait_got;
        bics_have   = bics_got || bics_cap;
        strait_have = strait_got || strait_cap;
        both_have   = bics_have && strait_have;
        run_exit    = (state == RUN) && (both_have || (cnt == TIMEOUT_LAST));
        report_done = (state == REPORT) && result_ack;

        // A same-cycle capture has not reached the latency register yet, so
        // the comparison uses the live counter for that engine.
        bics_lat    = bics_cap ? cnt : bics_cycles;
        strait_lat  = strait_cap ? cnt : strait_cycles;

        faster_next = 2'b00;
        case ({bics_have, strait_have})
            2'b11: begin
                if (bics_lat < strait_lat) begin
                    faster_next = 2'b01;
                end else if (bics_lat > strait_lat) begin
                    faster_next = 2'b10;
                end else begin
                    faster_next = 2'b11;
                end
            end
            2'b10:   faster_next = 2'b01;
            2'b01:   faster_next = 2'b10;
            default: faster_next = 2'b00;
        endcase
    end

    assign busy = (state != IDLE);

    // Run datapath: clears the record on launch, counts RUN cycles, latches
    // each engine's first done, and seals the record when RUN ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            bics_got      <= 1'b0;
            strait_got    <= 1'b0;
            bist_start    <= 1'b0;
            bics_cycles   <= '0;
            strait_cycles <= '0;
            bics_fail     <= 1'b0;
            strait_fail   <= 1'b0;
            timeout       <= 1'b0;
            faster        <= 2'b00;
            result_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_run) begin
                        cnt           <= '0;
                        bics_got      <= 1'b0;
                        strait_got    <= 1'b0;
                        bist_start    <= 1'b1;
                        bics_cycles   <= '0;
                        strait_cycles <= '0;
                        bics_fail     <= 1'b0;
                        strait_fail   <= 1'b0;
                        timeout       <= 1'b0;
                        faster        <= 2'b00;
                        result_valid  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (bics_cap) begin
                        bics_cycles <= cnt;
                        bics_fail   <= bics_error;
                        bics_got    <= 1'b1;
                    end
                    if (strait_cap) begin
                        strait_cycles <= cnt;
                        strait_fail   <= strait_error;
                        strait_got    <= 1'b1;
                    end
                    if (run_exit) begin
                        bist_start   <= 1'b0;
                        result_valid <= 1'b1;
                        faster       <= faster_next;
                        timeout      <= !both_have;
                        if (!bics_have) begin
                            bics_cycles <= CNT_MAX;
                            bics_fail   <= 1'b1;
                        end
                        if (!strait_have) begin
                            strait_cycles <= CNT_MAX;
                            strait_fail   <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (report_done) begin
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    bist_start   <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_race_monitor.sv
// Testbench for bist_race_monitor: directed races plus randomized ones, each
// checked against a run-level model derived from the engines' done-rise cycles.

module tb_bist_race_monitor;

    localparam int W = 16;
    localparam int T = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         run_req;
    logic         busy;
    logic         bist_start;
    logic         bics_done;
    logic         bics_error;
    logic         strait_done;
    logic         strait_error;
    logic [W-1:0] bics_cycles;
    logic [W-1:0] strait_cycles;
    logic         bics_fail;
    logic         strait_fail;
    logic         timeout;
    logic [1:0]   faster;
    logic         result_valid;
    logic         result_ack;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_bc;
    logic [W-1:0] exp_sc;
    logic         exp_bf;
    logic         exp_sf;
    logic         exp_to;
    logic [1:0]   exp_fa;
    int           exp_len;

    bist_race_monitor #(.CNT_WIDTH(W), .TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .run_req       (run_req),
        .busy          (busy),
        .bist_start    (bist_start),
        .bics_done     (bics_done),
        .bics_error    (bics_error),
        .strait_done   (strait_done),
        .strait_error  (strait_error),
        .bics_cycles   (bics_cycles),
        .strait_cycles (strait_cycles),
        .bics_fail     (bics_fail),
        .strait_fail   (strait_fail),
        .timeout       (timeout),
        .faster        (faster),
        .result_valid  (result_valid),
        .result_ack    (result_ack)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Done level for run cycle k: first rise at r, lasting l cycles (0 means
    // it stays high), optionally rising again for good at r2.
    function automatic logic doneLevel(input int k, input int r, input int l, input int r2);
        return (r >= 0 && k >= r && (l == 0 || k < r + l)) || (r2 >= 0 && k >= r2);
    endfunction

    // Run-level expectation from each engine's first done cycle and its error.
    task automatic computeModel(input int rb, input logic eb, input int rs, input logic es);
        bit cb;
        bit cs;
        cb      = (rb >= 0) && (rb <= T - 1);
        cs      = (rs >= 0) && (rs <= T - 1);
        exp_bc  = cb ? W'(rb) : {W{1'b1}};
        exp_sc  = cs ? W'(rs) : {W{1'b1}};
        exp_bf  = cb ? eb : 1'b1;
        exp_sf  = cs ? es : 1'b1;
        exp_to  = !(cb && cs);
        exp_len = (cb && cs) ? ((rb > rs ? rb : rs) + 1) : T;
        if (cb && cs) exp_fa = (rb < rs) ? 2'b01 : (rb > rs) ? 2'b10 : 2'b11;
        else if (cb)  exp_fa = 2'b01;
        else if (cs)  exp_fa = 2'b10;
        else          exp_fa = 2'b00;
    endtask

    task automatic checkRecord(input string tag);
        checkOutput({tag, "_bics_cycles"},   32'(bics_cycles),   32'(exp_bc));
        checkOutput({tag, "_strait_cycles"}, 32'(strait_cycles), 32'(exp_sc));
        checkOutput({tag, "_bics_fail"},     32'(bics_fail),     32'(exp_bf));
        checkOutput({tag, "_strait_fail"},   32'(strait_fail),   32'(exp_sf));
        checkOutput({tag, "_timeout"},       32'(timeout),       32'(exp_to));
        checkOutput({tag, "_faster"},        32'(faster),        32'(exp_fa));
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_bics_cycles"},   32'(bics_cycles),   32'd0);
        checkOutput({tag, "_strait_cycles"}, 32'(strait_cycles), 32'd0);
        checkOutput({tag, "_bics_fail"},     32'(bics_fail),     32'd0);
        checkOutput({tag, "_strait_fail"},   32'(strait_fail),   32'd0);
        checkOutput({tag, "_timeout"},       32'(timeout),       32'd0);
        checkOutput({tag, "_faster"},        32'(faster),        32'd0);
        checkOutput({tag, "_valid"},         32'(result_valid),  32'd0);
    endtask

    // One full race: launch, drive done/error per cycle, check the report,
    // hold it for a while, then acknowledge.
    task automatic applyStimulus(input int rb, input int lb, input int rb2, input logic eb,
                                 input int rs, input int ls, input int rs2, input logic es,
                                 input int hold, input logic noisy_req);
        int k;
        int high;
        computeModel(rb, eb, rs, es);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        checkOutput("start_bist_start", 32'(bist_start), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkCleared("start");
        k    = 0;
        high = 0;
        while (result_valid !== 1'b1 && k < T + 10) begin
            if (bist_start === 1'b1) high++;
            bics_done    = doneLevel(k, rb, lb, rb2);
            bics_error   = (k == rb) ? eb : (rb2 >= 0 && k >= rb2) ? 1'b1 : 1'($urandom);
            strait_done  = doneLevel(k, rs, ls, rs2);
            strait_error = (k == rs) ? es : (rs2 >= 0 && k >= rs2) ? 1'b1 : 1'($urandom);
            run_req      = noisy_req ? 1'($urandom) : 1'b0;
            tick();
            k++;
        end
        checkOutput("run_length", 32'(k), 32'(exp_len));
        checkOutput("bist_start_high_cycles", 32'(high), 32'(exp_len));
        checkOutput("report_bist_start", 32'(bist_start), 32'd0);
        checkOutput("report_busy", 32'(busy), 32'd1);
        checkOutput("report_valid", 32'(result_valid), 32'd1);
        checkRecord("report");
        for (int i = 0; i < hold; i++) begin
            bics_done    = 1'($urandom);
            bics_error   = 1'($urandom);
            strait_done  = 1'($urandom);
            strait_error = 1'($urandom);
            run_req      = noisy_req ? 1'($urandom) : 1'b0;
            result_ack   = 1'b0;
            tick();
            checkOutput("hold_valid", 32'(result_valid), 32'd1);
            checkOutput("hold_busy", 32'(busy), 32'd1);
            checkOutput("hold_bist_start", 32'(bist_start), 32'd0);
            checkRecord("hold");
        end
        result_ack = 1'b1;
        run_req    = noisy_req ? 1'($urandom) : 1'b0;
        tick();
        result_ack = 1'b0;
        run_req    = 1'b0;
        checkOutput("ack_valid", 32'(result_valid), 32'd0);
        checkOutput("ack_busy", 32'(busy), 32'd0);
        checkOutput("ack_bist_start", 32'(bist_start), 32'd0);
        checkRecord("idle");
    endtask

    // Launch a race with both engines silent and reset it after some cycles.
    task automatic resetMidRun(input int at);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int k = 0; k < at; k++) begin
            bics_done    = 1'b0;
            strait_done  = 1'b0;
            bics_error   = 1'($urandom);
            strait_error = 1'($urandom);
            tick();
        end
        checkOutput("pre_reset_bist_start", 32'(bist_start), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_bist_start", 32'(bist_start), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkCleared("midreset");
        tick();
    endtask

    // Directed scenarios first, then randomized races.
    initial begin
        int rb;
        int rs;
        rst          = 1'b1;
        run_req      = 1'b0;
        bics_done    = 1'b0;
        bics_error   = 1'b0;
        strait_done  = 1'b0;
        strait_error = 1'b0;
        result_ack   = 1'b0;
        repeat (3) tick();
        checkOutput("reset_bist_start", 32'(bist_start), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkCleared("reset");
        rst = 1'b0;
        tick();

        $display("[TB] staggered completion");
        applyStimulus(20, 0, -1, 1'b0, 300, 0, -1, 1'b0, 2, 1'b0);
        $display("[TB] same-cycle done");
        applyStimulus(50, 0, -1, 1'b0, 50, 0, -1, 1'b1, 2, 1'b0);
        $display("[TB] watchdog with STRAIT missing");
        applyStimulus(40, 0, -1, 1'b0, -1, 0, -1, 1'b0, 2, 1'b0);
        $display("[TB] handshake with ignored requests");
        applyStimulus(15, 0, -1, 1'b1, 25, 3, -1, 1'b0, 10, 1'b1);
        applyStimulus(5, 0, -1, 1'b0, 9, 0, -1, 1'b1, 1, 1'b0);
        $display("[TB] reset mid-run");
        resetMidRun(30);
        applyStimulus(12, 0, -1, 1'b1, 7, 0, -1, 1'b0, 1, 1'b0);
        $display("[TB] done glitch after capture");
        applyStimulus(10, 1, 60, 1'b0, 80, 0, -1, 1'b0, 1, 1'b0);
        $display("[TB] boundaries");
        applyStimulus(0, 0, -1, 1'b1, T - 1, 0, -1, 1'b0, 1, 1'b0);
        applyStimulus(T - 1, 0, -1, 1'b0, -1, 0, -1, 1'b0, 1, 1'b0);
        applyStimulus(-1, 0, -1, 1'b0, 100, 0, -1, 1'b1, 1, 1'b0);
        applyStimulus(-1, 0, -1, 1'b0, -1, 0, -1, 1'b0, 1, 1'b0);

        $display("[TB] randomized races");
        for (int n = 0; n < 6; n++) begin
            rb = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T + 40));
            rs = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T + 40));
            applyStimulus(rb, int'($urandom_range(0, 3)), -1, 1'($urandom),
                          rs, int'($urandom_range(0, 3)), -1, 1'($urandom),
                          int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bist_race_monitor.md
# bist_race_monitor

Hardware benchmark controller that launches the BICS-BIST engine and the STRAIT engine together from one start level. It counts each engine's latency in clock cycles, captures each pass/fail flag, and enforces a watchdog. It then presents one latched result record through a valid/ack handshake. It sits directly upstream of both BIST tops, driving their shared start, and downstream of their done and error outputs.

## Interface
- CNT_WIDTH, 16, width of the cycle counter and of the latency outputs.
- TIMEOUT, 5000, watchdog limit in RUN cycles. Legal range is 2 to 2^CNT_WIDTH-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- run_req  in  1  starts a run. Sampled only in IDLE.
- busy  out  1  high in RUN and REPORT.
- bist_start  out  1  registered start level, driven to both engines. High only in RUN.
- bics_done  in  1  BICS-BIST completion level.
- bics_error  in  1  BICS-BIST final error flag. Sampled with bics_done.
- strait_done  in  1  STRAIT completion level.
- strait_error  in  1  STRAIT error flag. Sampled with strait_done.
- bics_cycles  out  CNT_WIDTH  captured BICS latency.
- strait_cycles  out  CNT_WIDTH  captured STRAIT latency.
- bics_fail  out  1  BICS error, or BICS never completed.
- strait_fail  out  1  STRAIT error, or STRAIT never completed.
- timeout  out  1  watchdog expired before both engines completed.
- faster  out  2  01 means BICS is faster, 10 means STRAIT is faster, 11 means a tie, 00 means no comparison.
- result_valid  out  1  result record is stable.
- result_ack  in  1  consumer accepts the record.

## Operation
- FSM states are IDLE, RUN and REPORT.
- **IDLE**
  - If run_req=1, go to RUN.
  - On that same edge: clear all result outputs, clear the counter cnt, and clear the captured flags bics_got and strait_got.
  - Set bist_start=1 on that edge.
- **RUN**
  - cnt is 0 in the first RUN cycle and increments by 1 each cycle. It saturates at all-ones.
  - The first cycle with bics_done=1 and bics_got=0 does the following:
    - bics_cycles<=cnt
    - bics_fail<=bics_error
    - bics_got<=1
  - STRAIT capture is identical, using the strait_* signals.
  - After capture, further done or error activity from that engine is ignored, including deassertion.
  - Done inputs are level-sensitive.
  - This block does not check that done is low at run start. If done is already high, the engine is captured with latency 0.
- **RUN exits**
  - Both captured (the second capture can occur this cycle) → REPORT, timeout=0.
  - Otherwise, if cnt==TIMEOUT-1 → REPORT, timeout=1.
    - Each uncaptured engine gets cycles=all-ones and fail=1.
  - Capture on the cycle cnt==TIMEOUT-1 still counts.
- **Entering REPORT**
  - bist_start<=0.
  - faster is registered:
    - both captured: compare the two latencies, giving 01, 10, or 11 if equal.
    - only one captured: that engine wins, giving 01 or 10.
    - none captured: 00.
  - result_valid<=1.
- **REPORT**
  - Hold all outputs stable.
  - On result_ack=1, go to IDLE and set result_valid<=0.
  - Result fields keep their values in IDLE until the next run starts.
- run_req is ignored in RUN and REPORT; no request is queued.
- result_ack is ignored outside REPORT.
- busy = (state != IDLE).

## Timing
- Reset:
  - state=IDLE, cnt=0.
  - Every output is 0: bist_start, busy, cycles, fail, timeout, faster, result_valid.
- Reset mid-RUN or mid-REPORT:
  - Results are lost.
  - bist_start is low after the reset edge.
- run_req sampled at edge E gives bist_start=1 and busy=1 after E.
- Latency definition: for an engine whose done first rises N cycles after bist_start rises, cycles=N.
  - Example: bist_start high in cycle 0 and done seen in cycle 20 gives cycles=20.
- When the last capture happens in cycle k:
  - REPORT, result_valid=1 and bist_start=0 all take effect after edge k.
- Timeout with no captures:
  - bist_start is high for exactly TIMEOUT cycles.
- result_ack sampled at edge A gives result_valid=0 after A.
  - A run_req at A+1 is accepted.
- Minimum run-to-run spacing is RUN length + 1 REPORT cycle + 1 IDLE cycle.

## Test plan
- Staggered completion:
  - Stimulus: run_req, BICS done at cycle 20 with error=0, STRAIT done at cycle 300 with error=0.
  - Required response: bics_cycles=20, strait_cycles=300, faster=01, both fail=0, timeout=0, result_valid one cycle after the STRAIT capture, bist_start high for exactly 301 cycles.
- Same-cycle done:
  - Stimulus: both engines done at cycle 50, strait_error=1.
  - Required response: faster=11, strait_fail=1, bics_fail=0, REPORT entered after cycle 50.
- Watchdog with one engine missing:
  - Stimulus: TIMEOUT=100, BICS done at 40, STRAIT never done.
  - Required response: timeout=1, bics_cycles=40, strait_cycles=16'hFFFF, strait_fail=1, faster=01, bist_start high for 100 cycles.
- Handshake and ignored requests:
  - Stimulus: run_req pulses during RUN and REPORT; result_ack held low for 10 cycles, then pulsed.
  - Required response: no restart; outputs stable for all 10 cycles; valid drops after the ack edge; a new run_req then clears the results and restarts with cnt=0.
- Reset mid-RUN:
  - Stimulus: assert rst at cycle 30 with neither engine captured.
  - Required response: after that edge bist_start=0, busy=0, all outputs 0.
  - A subsequent run measures latency from its own start.
- Done glitch after capture:
  - Stimulus: BICS done high for one cycle at 10, then low, then high at 60 with error=1.
  - Required response: bics_cycles=10, bics_fail=0.
